icache_axi_rd: RTL and testbench
================================

Name: icache_axi_rd

Overview:
- Read-side responder between the instruction cache and the AXI bus.
- Accepts a cache-line refill request (rreq plus physical address) from the icache and issues one AXI4 read burst of LINE_WORDS beats.
- Assembles the returned beats into a full cache line.
- Returns the line with a one-cycle rend pulse; data is valid in the same cycle as rend.

Parameters:
LINE_WORDS, 8, words per cache line / beats per burst (power of two, 2..16)
ADDR_W, 32, address width
DATA_W, 32, AXI data width (one word per beat)
AXI_ID, 0, constant arid value (4 bits)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
icache_rreq_i  in  1  line refill request; held high by the icache until rend_o
icache_raddr_i  in  ADDR_W  physical address of the missing fetch
rend_o  out  1  one-cycle pulse: line complete
cacheline_rdata_o  out  LINE_WORDS*DATA_W  assembled line; word k is at bits [k*DATA_W +: DATA_W]
arid  out  4  = AXI_ID
araddr  out  ADDR_W  burst start address
arlen  out  8  = LINE_WORDS-1
arsize  out  3  = 3'b010
arburst  out  2  01 INCR (10 WRAP with the optional feature)
arvalid  out  1  address valid
arready  in  1  slave ready
rid  in  4  ignored
rdata  in  DATA_W  beat data
rresp  in  2  ignored
rlast  in  1  last beat flag
rvalid  in  1  beat valid
rready  out  1  master ready

Behaviour:
- Reset: state IDLE; all outputs 0 except the constants arid, arlen, arsize and arburst; beat counter 0; line register 0.
- Reset mid-burst: immediately returns to IDLE and drops arvalid/rready. System-wide reset covers the bus.
- FSM states: IDLE, AR, R, DONE.
- IDLE: on icache_rreq_i=1, latch the address and go to AR. araddr = {raddr[ADDR_W-1:log2(LINE_WORDS*4)], zeros} (line aligned). Beat counter cleared.
- AR: arvalid=1; araddr and all ar* fields stable while arvalid=1. On arready=1, go to R; arvalid drops the next cycle. Minimum latency from rreq to arvalid: 1 cycle.
- R: rready=1. On each rvalid handshake, write rdata into word slot idx, where idx = start_word + cnt mod LINE_WORDS (start_word=0 without the feature), then increment cnt. The burst completes on the handshake with cnt==LINE_WORDS-1, or on rlast=1, whichever comes first, then go to DONE. An rlast arriving early leaves the unfilled slots holding stale data (protocol error, not recovered).
- Back-to-back beats: one beat per cycle sustained; the next beat is accepted in the same cycle the counter advances.
- DONE: rend_o=1 for exactly one cycle with cacheline_rdata_o valid, then go to IDLE. cacheline_rdata_o holds its value until the next beat write.
- icache_rreq_i is sampled only in IDLE. A request still high in the cycle after DONE starts a new burst; the requester must drop rreq in that cycle.
- Address changes while the FSM is not in IDLE are ignored.
- Only one outstanding burst at a time; no read-data interleaving.

Optional Feature:
ICACHE_AXI_WRAP_EN: critical-word-first refill.
- Defined:
  - araddr = word-aligned icache_raddr_i; arburst=2'b10 (WRAP).
  - start_word = raddr[log2(LINE_WORDS*4)-1:2]; beat n is stored in slot (start_word+n) mod LINE_WORDS.
  - rend_o timing is unchanged (after the full line).
- Undefined:
  - araddr is line aligned; arburst=2'b01 (INCR); start_word=0.

Test Plan:
- Reset then rreq=1 with raddr=0x1FC0_0024, arready=1 at once → arvalid on the next cycle with araddr=0x1FC0_0020 (0x1FC0_0024 with WRAP_EN), arlen=7, arsize=2.
- 8 beats rdata=0xA0..0xA7, rvalid continuous, rlast on beat 8 → rend_o pulses once, 1 cycle after the last beat. Line word k=0xA0+k without WRAP_EN. With WRAP_EN and start_word=1, word 1=0xA0, word 0=0xA7.
- arready delayed 5 cycles → arvalid held and araddr stable for 6 cycles; no rready before the handshake.
- rvalid gapped (beats every 3 cycles) → line identical to the continuous case; cnt advances only on handshakes.
- rreq held high through DONE and the next cycle → exactly one rend_o, then a second arvalid starts the cycle after IDLE.
- rst_n low during beat 4 → arvalid=rready=rend_o=0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/icache_axi_rd.sv
// icache line refill over one AXI4 read burst; assembles beats into a line.
// Define ICACHE_AXI_WRAP_EN for critical-word-first (WRAP) refill.
module icache_axi_rd #(
   parameter int LINE_WORDS = 8,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int AXI_ID     = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         icache_rreq_i,
   input  logic [ADDR_W-1:0]            icache_raddr_i,
   output logic                         rend_o,
   output logic [LINE_WORDS*DATA_W-1:0] cacheline_rdata_o,
   output logic [3:0]                   arid,
   output logic [ADDR_W-1:0]            araddr,
   output logic [7:0]                   arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [3:0]                   rid,
   input  logic [DATA_W-1:0]            rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready
);

   localparam int OFF   = $clog2(LINE_WORDS * 4);
   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      AR,
      R,
      DONE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  cnt;
   logic [IDX_W-1:0]  start_word;
   logic [IDX_W-1:0]  first_word;
   logic [IDX_W-1:0]  idx;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        burst;
   logic              unused_ok;

`ifdef ICACHE_AXI_WRAP_EN
   assign req_addr   = {icache_raddr_i[ADDR_W-1:2], 2'b00};
   assign first_word = icache_raddr_i[OFF-1:2];
   assign burst      = 2'b10;
`else
   assign req_addr   = {icache_raddr_i[ADDR_W-1:OFF], {OFF{1'b0}}};
   assign first_word = '0;
   assign burst      = 2'b01;
`endif

   assign arid      = 4'(AXI_ID);
   assign arlen     = 8'(LINE_WORDS - 1);
   assign arsize    = 3'b010;
   assign arburst   = burst;
   assign idx       = start_word + cnt;
   assign unused_ok = ^{rid, rresp, icache_raddr_i[OFF-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         araddr            <= '0;
         arvalid           <= 1'b0;
         rready            <= 1'b0;
         rend_o            <= 1'b0;
         cnt               <= '0;
         start_word        <= '0;
         cacheline_rdata_o <= '0;
      end else begin
         rend_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (icache_rreq_i) begin
                  araddr     <= req_addr;
                  start_word <= first_word;
                  cnt        <= '0;
                  arvalid    <= 1'b1;
                  state      <= AR;
               end
            end
            AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= R;
               end
            end
            R: begin
               if (rvalid) begin
                  cacheline_rdata_o[idx*DATA_W +: DATA_W] <= rdata;
                  cnt <= cnt + 1'b1;
                  // early rlast ends the line; unfilled slots stay stale
                  if (cnt == LAST || rlast) begin
                     rready <= 1'b0;
                     rend_o <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_axi_rd.sv
// Self-checking bench for icache_axi_rd: vector table plus hand sequences.
// Line and address expectations come from a small refill model and queues.
module tb_icache_axi_rd;

   localparam int LW = 8;
   localparam int DW = 32;
   localparam int AW = 32;

`ifdef ICACHE_AXI_WRAP_EN
   localparam logic [1:0] EXP_BURST = 2'b10;
`else
   localparam logic [1:0] EXP_BURST = 2'b01;
`endif

   typedef logic [LW*DW-1:0] line_t;

   typedef struct {
      logic [31:0] addr;
      int          ardly;
      int          gap;
      logic [31:0] base;
      int          nbeats;
      bit          last_en;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          icache_rreq_i;
   logic [AW-1:0] icache_raddr_i;
   logic          rend_o;
   line_t         cacheline_rdata_o;
   logic [3:0]    arid;
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [3:0]    rid;
   logic [DW-1:0] rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;

   int pass_cnt = 0;
   int total_cnt = 0;
   int fail_cnt = 0;

   logic [AW-1:0] exp_addr_q[$];
   line_t         exp_line_q[$];
   line_t         model_mem;
   vec_t          vecs[5];

   icache_axi_rd #(
      .LINE_WORDS(LW),
      .ADDR_W(AW),
      .DATA_W(DW),
      .AXI_ID(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .icache_rreq_i(icache_rreq_i),
      .icache_raddr_i(icache_raddr_i),
      .rend_o(rend_o),
      .cacheline_rdata_o(cacheline_rdata_o),
      .arid(arid),
      .araddr(araddr),
      .arlen(arlen),
      .arsize(arsize),
      .arburst(arburst),
      .arvalid(arvalid),
      .arready(arready),
      .rid(rid),
      .rdata(rdata),
      .rresp(rresp),
      .rlast(rlast),
      .rvalid(rvalid),
      .rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef ICACHE_AXI_WRAP_EN
      return {a[31:2], 2'b00};
`else
      return {a[31:5], 5'b00000};
`endif
   endfunction

   function automatic line_t model_line(input logic [31:0] a,
                                        input logic [31:0] base,
                                        input int nb, input line_t prev);
      line_t l;
      int    sw;
      l = prev;
`ifdef ICACHE_AXI_WRAP_EN
      sw = int'(a[4:2]);
`else
      sw = 0;
`endif
      for (int n = 0; n < nb; n++) begin
         l[((sw + n) % LW)*DW +: DW] = base + n;
      end
      return l;
   endfunction

   task automatic burst(input logic [31:0] addr, input int ardly,
                        input int gap, input logic [31:0] base,
                        input int nbeats, input bit last_en,
                        input bit hold, input bit pre);
      logic [31:0] ea;
      line_t       el;
      int          w;
      if (!pre) begin
         @(negedge clk);
         icache_rreq_i  = 1'b1;
         icache_raddr_i = addr;
      end
      exp_addr_q.push_back(model_addr(addr));
      el = model_line(addr, base, nbeats, model_mem);
      model_mem = el;
      exp_line_q.push_back(el);
      @(negedge clk);
      chk("arvalid_lat", arvalid, 1'b1);
      ea = exp_addr_q.pop_front();
      chk("araddr", araddr, ea);
      chk("arlen", arlen, 8'd7);
      chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, EXP_BURST);
      chk("arid", arid, 4'd0);
      icache_raddr_i = addr ^ 32'hFFFF_0000;
      for (int i = 0; i < ardly; i++) begin
         chk("arvalid_hold", arvalid, 1'b1);
         chk("rready_early", rready, 1'b0);
         @(negedge clk);
         chk("araddr_stable", araddr, ea);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("arvalid_drop", arvalid, 1'b0);
      for (int n = 0; n < nbeats; n++) begin
         for (int g = 0; g < gap; g++) begin
            rvalid = 1'b0;
            chk("rready_gap", rready, 1'b1);
            @(negedge clk);
         end
         chk("rready_beat", rready, 1'b1);
         chk("rend_early", rend_o, 1'b0);
         rvalid = 1'b1;
         rdata  = base + n;
         rlast  = last_en && (n == nbeats - 1);
         @(negedge clk);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      w = 0;
      while (!rend_o && w < 8) begin
         @(negedge clk);
         w++;
      end
      chk("rend_lat", w, 0);
      chk("line", cacheline_rdata_o, exp_line_q.pop_front());
      chk("rready_done", rready, 1'b0);
      icache_raddr_i = addr;
      if (!hold) icache_rreq_i = 1'b0;
      @(negedge clk);
      chk("rend_once", rend_o, 1'b0);
      chk("line_hold", cacheline_rdata_o, el);
      chk("idle_no_ar", arvalid, 1'b0);
   endtask

   initial begin
      rst_n          = 1'b0;
      icache_rreq_i  = 1'b0;
      icache_raddr_i = '0;
      arready        = 1'b0;
      rid            = 4'd3;
      rdata          = '0;
      rresp          = 2'b00;
      rlast          = 1'b0;
      rvalid         = 1'b0;
      model_mem      = '0;

      vecs[0] = '{32'h1FC0_0024, 0, 0, 32'h0000_00A0, 8, 1'b1};
      vecs[1] = '{32'h1FC0_0024, 5, 0, 32'h0000_00B0, 8, 1'b1};
      vecs[2] = '{32'h0000_1234, 0, 2, 32'h0000_00C0, 8, 1'b1};
      vecs[3] = '{32'h8000_005C, 1, 1, 32'h0000_00D0, 8, 1'b0};
      vecs[4] = '{32'h0000_0040, 0, 0, 32'h0000_00E0, 4, 1'b1};

      repeat (2) @(negedge clk);
      chk("rst_rend", rend_o, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_araddr", araddr, 32'h0);
      chk("rst_line", cacheline_rdata_o, 256'h0);
      chk("rst_arlen", arlen, 8'd7);
      chk("rst_arsize", arsize, 3'b010);
      chk("rst_arburst", arburst, EXP_BURST);
      chk("rst_arid", arid, 4'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_arvalid", arvalid, 1'b0);

      for (int v = 0; v < 5; v++) begin
         burst(vecs[v].addr, vecs[v].ardly, vecs[v].gap, vecs[v].base,
               vecs[v].nbeats, vecs[v].last_en, 1'b0, 1'b0);
      end

      burst(32'h0000_0308, 0, 0, 32'h0000_1000, 8, 1'b1, 1'b1, 1'b0);
      burst(32'h0000_0308, 0, 0, 32'h0000_2000, 8, 1'b1, 1'b0, 1'b1);

      @(negedge clk);
      icache_rreq_i  = 1'b1;
      icache_raddr_i = 32'h0000_0100;
      @(negedge clk);
      chk("mid_arvalid", arvalid, 1'b1);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         rvalid = 1'b1;
         rdata  = 32'h0000_0050 + n;
         @(negedge clk);
      end
      rvalid = 1'b1;
      rdata  = 32'h0000_0053;
      chk("mid_rready_pre", rready, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_arvalid", arvalid, 1'b0);
      chk("mid_rst_rready", rready, 1'b0);
      chk("mid_rst_rend", rend_o, 1'b0);
      chk("mid_rst_line", cacheline_rdata_o, 256'h0);
      rvalid        = 1'b0;
      icache_rreq_i = 1'b0;
      model_mem     = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", arvalid, 1'b0);
      burst(32'h0000_0114, 2, 0, 32'h0000_00F0, 8, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
